// File: rtl/store_narrow_unit.sv
// store_narrow_unit: narrows a 32-bit store to a byte/half/word memory write.
// Ports: req_* request, mem_* memory write, resp_* completion pulse. Macro: STORE_RANGE_CHECK_EN.
module store_narrow_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  input  logic [1:0]            req_size,
  output logic                  mem_valid,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_be,
  output logic                  resp_valid,
  output logic                  resp_err,
  output logic                  resp_ovf
);

  typedef enum logic [1:0] {
    IDLE, ISSUE, RESP, ERR
  } state_t;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t          state;
  state_t          nstate;
  logic [CW-1:0]   cnt;
  logic            accept;
  logic            aligned;
  logic            timeout_hit;
  logic [3:0]      be_d;
  logic [31:0]     wdata_d;

  assign req_ready = (state == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  always_comb begin
    aligned = 1'b0;
    be_d    = 4'b0000;
    wdata_d = req_wdata;
    unique case (req_size)
      2'b00: begin
        aligned = 1'b1;
        be_d    = 4'b0001 << req_addr[1:0];
        wdata_d = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        aligned = !req_addr[0];
        be_d    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_d = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        aligned = (req_addr[1:0] == 2'b00);
        be_d    = 4'b1111;
      end
      default: aligned = 1'b0;
    endcase
  end

  // Final wait cycle without a handshake; a late mem_ready wins.
  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_LAST)
                       && !mem_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: begin
        if (accept) nstate = aligned ? ISSUE : ERR;
      end
      ISSUE: begin
        if (mem_ready)        nstate = RESP;
        else if (timeout_hit) nstate = ERR;
      end
      RESP:    nstate = IDLE;
      ERR:     nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || state != ISSUE) cnt <= '0;
    else if (!mem_ready)       cnt <= cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else if (accept) begin
      mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
      mem_wdata <= wdata_d;
      mem_be    <= be_d;
    end
  end

`ifdef STORE_RANGE_CHECK_EN
  logic ovf_d;
  logic ovf_q;

  // Truncated bits must equal the sign extension of the stored field.
  always_comb begin
    ovf_d = 1'b0;
    unique case (req_size)
      2'b00:   ovf_d = req_wdata[31:8] != {24{req_wdata[7]}};
      2'b01:   ovf_d = req_wdata[31:16] != {16{req_wdata[15]}};
      default: ovf_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)         ovf_q <= 1'b0;
    else if (accept) ovf_q <= ovf_d;
  end
`endif

  always_comb begin
    mem_valid  = (state == ISSUE);
    resp_valid = (state == RESP) || (state == ERR);
    resp_err   = (state == ERR);
`ifdef STORE_RANGE_CHECK_EN
    resp_ovf   = (state == RESP) && ovf_q;
`else
    resp_ovf   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_store_narrow_unit.sv
// tb_store_narrow_unit: directed vector bench for store_narrow_unit.
// Runs with TIMEOUT=4; follows STORE_RANGE_CHECK_EN for resp_ovf.
module tb_store_narrow_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        resp_valid;
  logic        resp_err;
  logic        resp_ovf;

  int checks = 0;
  int errors = 0;

`ifdef STORE_RANGE_CHECK_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    int          stall;
    logic [31:0] eaddr;
    logic [31:0] edata;
    logic [3:0]  ebe;
    logic        eerr;
    logic        eovf;
  } vec_t;

  store_narrow_unit #(
    .ADDR_WIDTH(32),
    .TIMEOUT(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_size(req_size),
    .mem_valid(mem_valid),
    .mem_ready(mem_ready),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_be(mem_be),
    .resp_valid(resp_valid),
    .resp_err(resp_err),
    .resp_ovf(resp_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    req_valid = 1'b1;
    req_addr  = v.addr;
    req_wdata = v.wdata;
    req_size  = v.size;
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    chk({tag, ".mv_pre"}, 32'(mem_valid), 32'd0);
    step();
    req_valid = 1'b0;
    if (v.eerr) begin
      chk({tag, ".rv"}, 32'(resp_valid), 32'd1);
      chk({tag, ".err"}, 32'(resp_err), 32'd1);
      chk({tag, ".ovf"}, 32'(resp_ovf), 32'd0);
      chk({tag, ".mv"}, 32'(mem_valid), 32'd0);
    end else begin
      for (int k = 0; k <= v.stall; k++) begin
        chk({tag, ".mv"}, 32'(mem_valid), 32'd1);
        chk({tag, ".addr"}, mem_addr, v.eaddr);
        chk({tag, ".data"}, mem_wdata, v.edata);
        chk({tag, ".be"}, 32'(mem_be), 32'(v.ebe));
        chk({tag, ".rv_wait"}, 32'(resp_valid), 32'd0);
        mem_ready = (k == v.stall);
        step();
      end
      mem_ready = 1'b0;
      chk({tag, ".rv"}, 32'(resp_valid), 32'd1);
      chk({tag, ".err"}, 32'(resp_err), 32'd0);
      chk({tag, ".ovf"}, 32'(resp_ovf), 32'(v.eovf & OVF_ON));
      chk({tag, ".mv_done"}, 32'(mem_valid), 32'd0);
    end
    step();
    chk({tag, ".rv_once"}, 32'(resp_valid), 32'd0);
    chk({tag, ".idle"}, 32'(req_ready), 32'd1);
  endtask

  vec_t vt[10];
  vec_t vw;

  initial begin
    vt[0] = '{32'h1003, 32'h000000A5, 2'b00, 0,
              32'h1000, 32'hA5A5A5A5, 4'b1000, 1'b0, 1'b1};
    vt[1] = '{32'h2002, 32'h12348001, 2'b01, 3,
              32'h2000, 32'h80018001, 4'b1100, 1'b0, 1'b1};
    vt[2] = '{32'h3001, 32'h11111111, 2'b10, 0,
              32'h0, 32'h0, 4'b0000, 1'b1, 1'b0};
    vt[3] = '{32'h3001, 32'h22222222, 2'b01, 0,
              32'h0, 32'h0, 4'b0000, 1'b1, 1'b0};
    vt[4] = '{32'h3000, 32'h33333333, 2'b11, 0,
              32'h0, 32'h0, 4'b0000, 1'b1, 1'b0};
    vt[5] = '{32'h5000, 32'hFFFFFF80, 2'b00, 0,
              32'h5000, 32'h80808080, 4'b0001, 1'b0, 1'b0};
    vt[6] = '{32'h5001, 32'h00000180, 2'b00, 1,
              32'h5000, 32'h80808080, 4'b0010, 1'b0, 1'b1};
    vt[7] = '{32'h5000, 32'h00008000, 2'b01, 0,
              32'h5000, 32'h80008000, 4'b0011, 1'b0, 1'b1};
    vt[8] = '{32'h6004, 32'h7FFFFFFF, 2'b10, 2,
              32'h6004, 32'h7FFFFFFF, 4'b1111, 1'b0, 1'b0};
    vt[9] = '{32'h7002, 32'hFFFF8123, 2'b00, 3,
              32'h7000, 32'h23232323, 4'b0100, 1'b0, 1'b1};
    vw    = '{32'h4000, 32'hDEADBEEF, 2'b10, 0,
              32'h4000, 32'hDEADBEEF, 4'b1111, 1'b0, 1'b0};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    req_size  = '0;
    mem_ready = 1'b0;
    step();
    step();
    chk("rst.ready", 32'(req_ready), 32'd0);
    chk("rst.mv", 32'(mem_valid), 32'd0);
    chk("rst.rv", 32'(resp_valid), 32'd0);
    chk("rst.addr", mem_addr, 32'd0);
    chk("rst.data", mem_wdata, 32'd0);
    chk("rst.be", 32'(mem_be), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst.ready_rel", 32'(req_ready), 32'd1);
    step();

    for (int i = 0; i < 10; i++)
      run_vec(vt[i], $sformatf("vec%0d", i));

    // Timeout: mem_ready held low for the whole wait.
    req_valid = 1'b1;
    req_addr  = 32'h8000;
    req_wdata = 32'h0BADF00D;
    req_size  = 2'b10;
    step();
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("to.mv%0d", k), 32'(mem_valid), 32'd1);
      chk($sformatf("to.rv%0d", k), 32'(resp_valid), 32'd0);
      step();
    end
    chk("to.mv_drop", 32'(mem_valid), 32'd0);
    chk("to.rv", 32'(resp_valid), 32'd1);
    chk("to.err", 32'(resp_err), 32'd1);
    chk("to.ovf", 32'(resp_ovf), 32'd0);
    step();
    chk("to.rv_once", 32'(resp_valid), 32'd0);
    chk("to.idle", 32'(req_ready), 32'd1);

    // Reset during the second ISSUE cycle.
    req_valid = 1'b1;
    req_addr  = 32'h9000;
    req_wdata = 32'h12345678;
    req_size  = 2'b10;
    step();
    req_valid = 1'b0;
    chk("mr.mv1", 32'(mem_valid), 32'd1);
    step();
    chk("mr.mv2", 32'(mem_valid), 32'd1);
    rst = 1'b1;
    step();
    chk("mr.mv_off", 32'(mem_valid), 32'd0);
    chk("mr.rv", 32'(resp_valid), 32'd0);
    chk("mr.addr", mem_addr, 32'd0);
    chk("mr.be", 32'(mem_be), 32'd0);
    chk("mr.ready_rst", 32'(req_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("mr.ready", 32'(req_ready), 32'd1);
    step();
    chk("mr.rv_after", 32'(resp_valid), 32'd0);
    chk("mr.mv_after", 32'(mem_valid), 32'd0);
    run_vec(vw, "mr.word");

    // mem_ready outside ISSUE does nothing.
    mem_ready = 1'b1;
    step();
    chk("idle.rdy_ign_mv", 32'(mem_valid), 32'd0);
    chk("idle.rdy_ign_rv", 32'(resp_valid), 32'd0);
    mem_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/store_narrow_unit.md
Name: store_narrow_unit

Overview:
- Store-path counterpart of the immediate/load sign extender: narrows a 32-bit register value to a byte, halfword or word store.
- Produces a word-aligned data-memory write with replicated lane data and byte enables.
- Sits between the datapath store request and the data memory port.
- Adds a valid/ready memory handshake, alignment checking, a response pulse and a bounded wait timeout.

Parameters:
- ADDR_WIDTH, 32, width of the byte address and of mem_addr.
- TIMEOUT, 16, maximum cycles mem_valid stays high without mem_ready before the store aborts; 0 = wait forever.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  1  store request valid.
- req_ready  output  1  unit can accept a request.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  32  register value to store.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- mem_valid  output  1  memory write valid.
- mem_ready  input  1  memory accepts the write.
- mem_addr  output  ADDR_WIDTH  word address, low 2 bits zero.
- mem_wdata  output  32  lane-replicated store data.
- mem_be  output  4  byte enables.
- resp_valid  output  1  one-cycle completion pulse.
- resp_err  output  1  misaligned, illegal size or timeout; valid with resp_valid.
- resp_ovf  output  1  narrowing lost information; valid with resp_valid (see optional feature).

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset state: state = IDLE; mem_valid, mem_addr, mem_wdata, mem_be, resp_valid, resp_err, resp_ovf and the timeout counter all 0.
- req_ready = (state==IDLE) && !rst. It is combinational from state.
- States: IDLE, ISSUE, RESP, ERR.
- IDLE:
  - On req_valid && req_ready, register addr, wdata and size.
  - Alignment rules: half needs addr[0]==0; word needs addr[1:0]==0; size 11 is always illegal.
  - Legal request -> ISSUE. Misaligned or illegal -> ERR, and no memory access is made.
- ISSUE:
  - mem_valid = 1. Payload is registered and held stable until the handshake completes.
  - Timeout counter increments each cycle without mem_ready.
  - mem_ready -> RESP.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT-1 without mem_ready: drop mem_valid and go to ERR.
  - If mem_ready arrives in that same final cycle, the handshake wins and the next state is RESP.
- RESP: resp_valid = 1, resp_err = 0, for exactly one cycle, then IDLE.
- ERR: resp_valid = 1, resp_err = 1, resp_ovf = 0, for one cycle, then IDLE.
- Responses have no backpressure.
- Lane mapping:
  - mem_addr = {addr[ADDR_WIDTH-1:2], 2'b00}.
  - Byte: mem_wdata = {4{wdata[7:0]}}; mem_be = 4'b0001 << addr[1:0].
  - Half: mem_wdata = {2{wdata[15:0]}}; mem_be = addr[1] ? 4'b1100 : 4'b0011.
  - Word: mem_wdata = wdata; mem_be = 4'b1111.
- Latency: request accepted in cycle N; mem_valid high in N+1; with mem_ready in N+1, resp_valid in N+2. An error request gives resp_valid in N+1.
- Throughput: one request in flight at a time. The next request can be accepted in the cycle after resp_valid.
- Reset mid-operation: mem_valid is low in the cycle after rst is sampled. The in-flight store is abandoned with no response, and all outputs return to reset values.
- mem_ready outside ISSUE is ignored.

Optional Feature:
- Macro: STORE_RANGE_CHECK_EN.
- Defined: on a successful store, resp_ovf = 1 when the truncated bits are not the sign extension of the stored field.
  - Byte: req_wdata[31:8] != {24{wdata[7]}}.
  - Half: req_wdata[31:16] != {16{wdata[15]}}.
  - Word: always 0.
  - The store is still performed; resp_err is unaffected.
- Undefined: resp_ovf is tied to 0. No check logic is built.

Test Plan:
- Byte store, addr 0x1003, wdata 0x000000A5, mem_ready immediately -> mem_addr 0x1000, mem_wdata 0xA5A5A5A5, mem_be 0001 shifted by 3 = 1000, resp_valid at N+2 with err 0.
- Half store, addr 0x2002, wdata 0x12348001, mem_ready after 3 stall cycles -> mem_valid and payload stable for 4 cycles, mem_wdata 0x80018001, mem_be 1100, one resp pulse.
- Word store at addr 0x3001, then half at 0x3001, then size 11 -> each gives resp_valid with resp_err 1 at N+1; mem_valid never asserted.
- TIMEOUT=4 with mem_ready held low -> mem_valid high for exactly 4 cycles, then resp_err 1.
- Repeat with mem_ready in the 4th cycle -> normal response, err 0.
- rst asserted in the second ISSUE cycle -> mem_valid 0 next cycle, no resp_valid, req_ready 1 after rst drops; then a word store at 0x4000 with 0xDEADBEEF gives mem_be 1111.
- With STORE_RANGE_CHECK_EN: byte 0xFFFFFF80 -> resp_ovf 0; byte 0x00000180 -> resp_ovf 1; half 0x00008000 -> resp_ovf 1. Without the macro, all three give resp_ovf 0.
